fence_t_sequencer: RTL
======================

# fence_t_sequencer

Sequences a `fence.t` (timing-channel fence) request from the commit stage into ordered flush pulses for the flush controller's `fence_t` vector. The D-cache flush is issued first and its acknowledge awaited; then all other selected structures are flushed in one pulse. Completion can optionally be padded to a fixed minimum latency so fence duration does not depend on cache state. The block sits between commit and the flush controller and halts commit while active.

## Interface
- `PadCycles`, default 64: minimum cycles from request acceptance to `done_o` when padding is enabled; 0 disables padding.
- `AckTimeout`, default 1024: maximum cycles spent waiting for the D-cache acknowledge before abort.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `fence_t_req_i`  in  1  single-cycle request from commit.
- `fence_t_sel_i`  in  14  structure-select vector, sampled with the request. Bit map: 0 IF, 1 unissued, 2 ID, 3 EX, 4 dcache, 5 icache, 6 TLB, 7 BP, 8 dcache LFSR, 9 icache LFSR, 10 TLB PLRU, 11 dcache mem arb, 12 wbuffer arb, 13 dcache FIFO.
- `pad_en_i`  in  1  enable latency padding; sampled with the request.
- `flush_dcache_ack_i`  in  1  D-cache flush complete.
- `fence_t_o`  out  14  flush pulse vector to the flush controller.
- `busy_o`  out  1  sequencer active; halts commit.
- `done_o`  out  1  one-cycle completion pulse.
- `timeout_o`  out  1  one-cycle pulse, coincident with `done_o`, when the D-cache acknowledge timed out.

## Operation
- States: IDLE, DC_REQ, DC_WAIT, REST, PAD, DONE. Registered: state, `sel_q`, `pad_q`, pad counter `cnt_q`, timeout counter `to_q`, timeout flag `to_flag_q`.
- IDLE: when `fence_t_req_i`=1, latch `sel_q`=`fence_t_sel_i` and `pad_q`=`pad_en_i`, clear both counters and `to_flag_q`. Next state is DC_REQ if `fence_t_sel_i[4]`, else REST.
- DC_REQ: `fence_t_o` = `sel_q & 14'h0010` for exactly one cycle, then DC_WAIT.
- DC_WAIT: `fence_t_o`=0.
  - `flush_dcache_ack_i`=1: go to REST. An ack in the DC_REQ cycle is ignored.
  - Otherwise `to_q` increments. When `to_q` reaches `AckTimeout-1` with no ack, set `to_flag_q` and go to REST.
- REST: `fence_t_o` = `sel_q & ~14'h0010` for one cycle.
  - Next state is PAD if `pad_q` and `PadCycles`>0, else DONE.
  - `sel_q`=0 is legal: the vector is all zero and the sequence still completes.
- PAD: `fence_t_o`=0. Exit to DONE in the cycle where `cnt_q >= PadCycles`. PAD always lasts at least one cycle.
- DONE: `done_o`=1 and `timeout_o`=`to_flag_q`. Next state is IDLE.
- `busy_o`=1 in every state except IDLE, including DONE.
- `cnt_q`: 0 in the first cycle after acceptance, then +1 every busy cycle.
  - Width is `$clog2(PadCycles+1)`, minimum 1.
  - Saturates at its maximum and never wraps.
- `to_q` width is `$clog2(AckTimeout)`, minimum 1.
- A `fence_t_req_i` received while not in IDLE is ignored. Bench assertion: never asserted while `busy_o`=1.
- `fence_t_o` bits are driven only in DC_REQ and REST. Never hold any bit for more than one cycle.

## Timing
- Reset: state IDLE; all outputs 0; `sel_q`, `pad_q`, counters and `to_flag_q` cleared.
- Reset asserted mid-sequence: return to IDLE immediately. No `done_o` is emitted.
- Request in cycle 0; first busy cycle is cycle 1.
- Let T be the REST cycle:
  - no D-cache flush: T=1;
  - D-cache flush with ack first seen in cycle A ≥ 3: T=A+1.
- `done_o` cycle:
  - padding off: T+1;
  - padding on: max(T, PadCycles)+2.
- All outputs are pure functions of registered state. There is no combinational path from any input to any output.

## Test plan
- Request with sel=14'h000F, pad off -> `fence_t_o`=14'h000F in cycle 1, `done_o` in cycle 2, `busy_o` high in cycles 1-2.
- Request with sel=14'h3FFF, pad off, ack in cycle 5:
  - `fence_t_o`=14'h0010 in cycle 1;
  - `fence_t_o`=0 in cycles 2-5;
  - `fence_t_o`=14'h3FEF in cycle 6;
  - `done_o` in cycle 7.
- Request with sel=14'h0001, pad on, PadCycles=64 -> `done_o` exactly in cycle 66. With sel=14'h0010 and ack in cycle 80 -> REST in cycle 81, `done_o` in cycle 83.
- Request with sel=14'h0010, AckTimeout=16, ack never asserted -> REST in cycle 18, `done_o` and `timeout_o` both in cycle 19.
- Second request during busy -> ignored, with no change to outputs or to `sel_q`. `rst_ni` low in cycle 3 of a DC_WAIT -> all outputs 0 next edge, no `done_o`; a fresh request afterwards completes normally.
- Request with sel=0, pad off -> `fence_t_o`=0 throughout, `done_o` in cycle 2.

Source files
------------

// File: rtl/fence_t_sequencer.sv
// Orders a fence.t request into flush pulses: the D-cache goes first and its ack is awaited,
// then everything else is flushed together. Completion can optionally be padded to a minimum latency.
module fence_t_sequencer #(
   parameter int unsigned PadCycles  = 64,
   parameter int unsigned AckTimeout = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        fence_t_req_i,
   input  logic [13:0] fence_t_sel_i,
   input  logic        pad_en_i,
   input  logic        flush_dcache_ack_i,
   output logic [13:0] fence_t_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        timeout_o
);

   // state   | meaning
   // IDLE    | waiting for a request from commit
   // DC_REQ  | one-cycle D-cache flush pulse
   // DC_WAIT | waiting for the D-cache ack, bounded by AckTimeout
   // REST    | one-cycle pulse for every other selected structure
   // PAD     | holding until the minimum fence latency has elapsed
   // DONE    | completion pulse, timeout flag reported

   localparam int unsigned CntW = ($clog2(PadCycles + 1) > 1) ? $clog2(PadCycles + 1) : 1;
   localparam int unsigned ToW  = ($clog2(AckTimeout) > 1) ? $clog2(AckTimeout) : 1;
   localparam logic [CntW-1:0] CntMax = '1;
   localparam logic [CntW-1:0] PadLim = CntW'(PadCycles);
   localparam logic [ToW-1:0]  ToLim  = ToW'(AckTimeout - 1);
   localparam logic [13:0]     DcBit  = 14'h0010;
   localparam logic            PadOn  = (PadCycles != 0);

   typedef enum logic [2:0] {IDLE, DC_REQ, DC_WAIT, REST, PAD, DONE} state_e;

   state_e          state_q;
   logic [13:0]     sel_q;
   logic            pad_q;
   logic [CntW-1:0] cnt_q;
   logic [ToW-1:0]  to_q;
   logic            to_flag_q;

   // Outputs are registered alongside the transition that enters the state they belong to.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         pad_q     <= 1'b0;
         cnt_q     <= '0;
         to_q      <= '0;
         to_flag_q <= 1'b0;
         fence_t_o <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         fence_t_o <= '0;
         done_o    <= 1'b0;
         timeout_o <= 1'b0;
         if (state_q != IDLE && cnt_q != CntMax) begin
            cnt_q <= cnt_q + CntW'(1);
         end
         case (state_q)
            IDLE: begin
               if (fence_t_req_i) begin
                  sel_q     <= fence_t_sel_i;
                  pad_q     <= pad_en_i;
                  cnt_q     <= '0;
                  to_q      <= '0;
                  to_flag_q <= 1'b0;
                  busy_o    <= 1'b1;
                  if (fence_t_sel_i[4]) begin
                     state_q   <= DC_REQ;
                     fence_t_o <= fence_t_sel_i & DcBit;
                  end else begin
                     state_q   <= REST;
                     fence_t_o <= fence_t_sel_i & ~DcBit;
                  end
               end
            end
            DC_REQ: begin
               state_q <= DC_WAIT;
            end
            DC_WAIT: begin
               if (flush_dcache_ack_i) begin
                  state_q   <= REST;
                  fence_t_o <= sel_q & ~DcBit;
               end else if (to_q == ToLim) begin
                  to_flag_q <= 1'b1;
                  state_q   <= REST;
                  fence_t_o <= sel_q & ~DcBit;
               end else begin
                  to_q <= to_q + ToW'(1);
               end
            end
            REST: begin
               if (pad_q && PadOn) begin
                  state_q <= PAD;
               end else begin
                  state_q   <= DONE;
                  done_o    <= 1'b1;
                  timeout_o <= to_flag_q;
               end
            end
            PAD: begin
               if (cnt_q >= PadLim) begin
                  state_q   <= DONE;
                  done_o    <= 1'b1;
                  timeout_o <= to_flag_q;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_o  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule
